// File: rtl/elastic_operand_join.sv
// -----------------------------------------------------------------------------
// elastic_operand_join
//
// PE input stage that sits directly after the neighbour PEs' elastic forks.
// It picks operand A (and optionally operand B) from one of the
// NEIGHBOR_PE_NUM incoming elastic links and holds each operand in a 2-entry
// elastic buffer. It then presents the pair to the ALU as one joined
// valid/stop token.
//
// stop_input depends only on the registered buffer occupancy and the static
// configuration. This cuts the combinational stop chain back into the
// upstream forks.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   reset_n        synchronous active-low reset
//   input_data     per-link operand data from the neighbour forks
//   valid_input    per-link valid
//   stop_input     per-link back-pressure to the neighbour forks
//   select_a/b     source link for operand A / B (static while tokens in flight)
//   use_b          1 = two-operand op, 0 = operand B ignored
//   flush          synchronous clear of both buffers (context switch)
//   output_data_a  head of the A buffer
//   output_data_b  head of the B buffer (don't-care when use_b = 0)
//   valid_output   joined token available
//   stop_output    downstream back-pressure
// -----------------------------------------------------------------------------
module elastic_operand_join #(
    parameter int DATA_WIDTH      = 32,
    parameter int NEIGHBOR_PE_NUM = 4,
    parameter int SEL_WIDTH       = $clog2(NEIGHBOR_PE_NUM)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [DATA_WIDTH-1:0]      input_data [NEIGHBOR_PE_NUM],
    input  logic [NEIGHBOR_PE_NUM-1:0] valid_input,
    output logic [NEIGHBOR_PE_NUM-1:0] stop_input,
    input  logic [SEL_WIDTH-1:0]       select_a,
    input  logic [SEL_WIDTH-1:0]       select_b,
    input  logic                       use_b,
    input  logic                       flush,
    output logic [DATA_WIDTH-1:0]      output_data_a,
    output logic [DATA_WIDTH-1:0]      output_data_b,
    output logic                       valid_output,
    input  logic                       stop_output
);

    // A buffer state
    logic [DATA_WIDTH-1:0] mem_a [2];
    logic                  wr_ptr_a;
    logic                  rd_ptr_a;
    logic [1:0]            count_a;

    // B buffer state
    logic [DATA_WIDTH-1:0] mem_b [2];
    logic                  wr_ptr_b;
    logic                  rd_ptr_b;
    logic [1:0]            count_b;

    // Configuration seen at the previous edge, used only by the assertion
    logic [SEL_WIDTH-1:0]  select_a_p1;
    logic [SEL_WIDTH-1:0]  select_b_p1;
    logic                  use_b_p1;

    logic full_a;
    logic full_b;
    logic empty_a;
    logic empty_b;
    logic push_a;
    logic push_b;
    logic pop;
    logic pop_a;
    logic pop_b;
    logic [DATA_WIDTH-1:0] data_in_a;
    logic [DATA_WIDTH-1:0] data_in_b;

    assign full_a  = (count_a == 2'd2);
    assign full_b  = (count_b == 2'd2);
    assign empty_a = (count_a == 2'd0);
    assign empty_b = (count_b == 2'd0);

    // A link that feeds neither operand is held off permanently.
    // A link that feeds both operands is stopped when either buffer is full,
    // so the one transfer always lands in both buffers together.
    for (genvar i = 0; i < NEIGHBOR_PE_NUM; i++) begin : g_stop
        logic hit_a;
        logic hit_b;
        assign hit_a = (select_a == SEL_WIDTH'(i));
        assign hit_b = use_b && (select_b == SEL_WIDTH'(i));
        assign stop_input[i] = !(hit_a || hit_b)
                             || (hit_a && full_a)
                             || (hit_b && full_b);
    end

    assign data_in_a = input_data[select_a];
    assign data_in_b = input_data[select_b];

    assign push_a = valid_input[select_a] && !stop_input[select_a];
    assign push_b = use_b && valid_input[select_b] && !stop_input[select_b];

    assign valid_output = !empty_a && (!use_b || !empty_b);
    assign pop          = valid_output && !stop_output;
    assign pop_a        = pop;
    assign pop_b        = pop && use_b;

    assign output_data_a = mem_a[rd_ptr_a];
    assign output_data_b = mem_b[rd_ptr_b];

    // A buffer. A full buffer does not accept a push even while it pops,
    // so the count stays within 0..2 without a bypass path.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_a <= 1'b0;
            rd_ptr_a <= 1'b0;
            count_a  <= 2'd0;
            mem_a[0] <= '0;
            mem_a[1] <= '0;
        end else begin
            if (push_a) begin
                mem_a[wr_ptr_a] <= data_in_a;
                wr_ptr_a        <= ~wr_ptr_a;
            end
            if (pop_a) begin
                rd_ptr_a <= ~rd_ptr_a;
            end
            count_a <= count_a + {1'b0, push_a} - {1'b0, pop_a};
        end
    end

    // B buffer
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            wr_ptr_b <= 1'b0;
            rd_ptr_b <= 1'b0;
            count_b  <= 2'd0;
            mem_b[0] <= '0;
            mem_b[1] <= '0;
        end else begin
            if (push_b) begin
                mem_b[wr_ptr_b] <= data_in_b;
                wr_ptr_b        <= ~wr_ptr_b;
            end
            if (pop_b) begin
                rd_ptr_b <= ~rd_ptr_b;
            end
            count_b <= count_b + {1'b0, push_b} - {1'b0, pop_b};
        end
    end

    // The configuration may only move while both buffers are empty or
    // together with a flush. Otherwise buffered operands would be joined
    // under the wrong routing.
    always_ff @(posedge clk) begin
        select_a_p1 <= select_a;
        select_b_p1 <= select_b;
        use_b_p1    <= use_b;
        if (reset_n && !flush && (!empty_a || !empty_b)) begin
            assert (select_a == select_a_p1 && select_b == select_b_p1
                    && use_b == use_b_p1);
        end
    end

endmodule

// File: tb/tb_elastic_operand_join.sv
module tb_elastic_operand_join;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] input_data [N];
    logic [N-1:0]  valid_input;
    logic [N-1:0]  stop_input;
    logic [SW-1:0] select_a;
    logic [SW-1:0] select_b;
    logic          use_b;
    logic          flush;
    logic [DW-1:0] output_data_a;
    logic [DW-1:0] output_data_b;
    logic          valid_output;
    logic          stop_output;

    always #5 clk = ~clk;

    elastic_operand_join #(
        .DATA_WIDTH      (DW),
        .NEIGHBOR_PE_NUM (N)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .input_data    (input_data),
        .valid_input   (valid_input),
        .stop_input    (stop_input),
        .select_a      (select_a),
        .select_b      (select_b),
        .use_b         (use_b),
        .flush         (flush),
        .output_data_a (output_data_a),
        .output_data_b (output_data_b),
        .valid_output  (valid_output),
        .stop_output   (stop_output)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each operand buffer is a FIFO of at most two entries.
    // The zero flags track "cleared and not yet written".
    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    bit            zero_a;
    bit            zero_b;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_stop();
        logic [N-1:0] s;
        for (int i = 0; i < N; i++) begin
            bit ha;
            bit hb;
            ha   = (select_a == i);
            hb   = use_b && (select_b == i);
            s[i] = !(ha || hb) || (ha && qa.size() == 2) || (hb && qb.size() == 2);
        end
        return s;
    endfunction

    function automatic bit model_valid();
        return (qa.size() > 0) && (!use_b || qb.size() > 0);
    endfunction

    // Inputs are set just after a rising edge. Outputs are checked at the
    // falling edge, and the model advances at the next rising edge.
    task automatic cycle();
        logic [N-1:0] es;
        bit ev;
        bit pa;
        bit pb;
        bit pop;
        #4;
        es = model_stop();
        ev = model_valid();
        check_eq("stop_input", stop_input, es);
        check_eq("valid_output", valid_output, ev);
        if (ev) begin
            check_eq("data_a", output_data_a, qa[0]);
            if (use_b) check_eq("data_b", output_data_b, qb[0]);
        end
        if (zero_a) check_eq("data_a_zero", output_data_a, 0);
        if (zero_b && use_b) check_eq("data_b_zero", output_data_b, 0);
        pa  = valid_input[select_a] && !es[select_a];
        pb  = use_b && valid_input[select_b] && !es[select_b];
        pop = ev && !stop_output;
        @(posedge clk);
        if (!reset_n || flush) begin
            qa.delete();
            qb.delete();
            zero_a = 1;
            zero_b = 1;
        end else begin
            if (pop) begin
                void'(qa.pop_front());
                if (use_b) void'(qb.pop_front());
            end
            if (pa) begin
                qa.push_back(input_data[select_a]);
                zero_a = 0;
            end
            if (pb) begin
                qb.push_back(input_data[select_b]);
                zero_b = 0;
            end
        end
        #1;
    endtask

    task automatic idle();
        valid_input = '0;
        for (int i = 0; i < N; i++) input_data[i] = $urandom;
    endtask

    task automatic reconfig(input int a, input int b, input bit ub);
        select_a = SW'(a);
        select_b = SW'(b);
        use_b    = ub;
        idle();
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
    endtask

    task automatic send(input int link, input logic [DW-1:0] d);
        idle();
        input_data[link]  = d;
        valid_input[link] = 1'b1;
        cycle();
        valid_input = '0;
    endtask

    initial begin
        logic [DW-1:0] stream [4];
        int sent;
        int cyc;

        reset_n     = 1'b0;
        flush       = 1'b0;
        stop_output = 1'b0;
        select_a    = 2'd2;
        select_b    = 2'd0;
        use_b       = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        zero_a = 1;
        zero_b = 1;

        // Reset and single token on link 2 as operand A
        cycle();
        reset_n = 1'b1;
        send(2, 32'h11);
        cycle();
        check_eq("t1_stop_unsel", stop_input, 4'b1011);
        idle();
        cycle();

        // Two operands arriving at different times
        reconfig(0, 3, 1);
        send(0, 32'hA);
        cycle();
        send(3, 32'hB);
        cycle();
        cycle();

        // Back-pressure with a four-token stream on link 1
        reconfig(1, 0, 0);
        stream[0] = 5;
        stream[1] = 6;
        stream[2] = 7;
        stream[3] = 8;
        sent = 0;
        stop_output = 1'b1;
        for (cyc = 0; cyc < 24 && sent < 4; cyc++) begin
            logic [N-1:0] es;
            idle();
            input_data[1]  = stream[sent];
            valid_input[1] = 1'b1;
            es = model_stop();
            if (cyc == 5) stop_output = 1'b0;
            if (!es[1]) sent++;
            cycle();
        end
        check_eq("t3_all_sent", sent, 4);
        idle();
        repeat (4) cycle();

        // Shared link feeding both operands, both buffers full
        reconfig(1, 1, 1);
        stop_output = 1'b1;
        send(1, 32'h31);
        send(1, 32'h32);
        idle();
        input_data[1]  = 32'h33;
        valid_input[1] = 1'b1;
        cycle();
        check_eq("t4_stopped", stop_input[1], 1'b1);
        stop_output = 1'b0;
        cycle();
        stop_output = 1'b1;
        cycle();
        stop_output = 1'b0;
        idle();
        repeat (4) cycle();

        // Continuous stream with no back-pressure
        reconfig(3, 2, 1);
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < N; i++) input_data[i] = $urandom;
            valid_input = 4'b1100;
            cycle();
            check_eq("t5_no_stall", stop_input[3:2], 2'b00);
        end
        idle();
        cycle();

        // Flush with two tokens buffered, then reset with two tokens buffered
        stop_output = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) input_data[i] = $urandom;
            valid_input = 4'b1100;
            cycle();
        end
        idle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_eq("t6_flush_valid", valid_output, 1'b0);
        stop_output = 1'b0;
        idle();
        input_data[3]  = 32'h77;
        input_data[2]  = 32'h88;
        valid_input    = 4'b1100;
        cycle();
        idle();
        cycle();
        stop_output = 1'b1;
        valid_input = 4'b1100;
        cycle();
        cycle();
        idle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        check_eq("t6_reset_valid", valid_output, 1'b0);
        stop_output = 1'b0;
        send(3, 32'h99);
        send(2, 32'haa);
        cycle();

        // Randomized traffic with occasional reconfiguration and reset
        for (int k = 0; k < 800; k++) begin
            if (k % 60 == 0) begin
                reconfig($urandom_range(0, N - 1), $urandom_range(0, N - 1), 1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < N; i++) input_data[i] = $urandom;
            valid_input = N'($urandom_range(0, 15));
            stop_output = ($urandom_range(0, 2) == 0);
            reset_n     = ($urandom_range(0, 149) != 0);
            cycle();
            reset_n = 1'b1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
